// File: rtl/tick_stopwatch_bcd_if.sv
// Control and display bundle between the timer stage, the stopwatch and the display logic.
// The master drives the commands and the tick. The slave (the stopwatch) drives the time and lap digits.
interface tick_stopwatch_bcd_if;
  logic       tick;
  logic       start;
  logic       stop;
  logic       clear;
  logic       lap;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic [3:0] lap_sec_ones;
  logic [3:0] lap_sec_tens;
  logic [3:0] lap_min_ones;
  logic [3:0] lap_min_tens;
  logic       lap_valid;
  logic       running;
  logic       rollover;

  modport master (
    output tick, start, stop, clear, lap,
    input  sec_ones, sec_tens, min_ones, min_tens,
    input  lap_sec_ones, lap_sec_tens, lap_min_ones, lap_min_tens,
    input  lap_valid, running, rollover
  );

  modport slave (
    input  tick, start, stop, clear, lap,
    output sec_ones, sec_tens, min_ones, min_tens,
    output lap_sec_ones, lap_sec_tens, lap_min_ones, lap_min_tens,
    output lap_valid, running, rollover
  );
endinterface

// File: rtl/tick_stopwatch_bcd.sv
// BCD mm:ss stopwatch driven by one-second ticks. It has start/stop/clear control, lap capture and a
// rollover pulse. Minutes wrap after MIN_LIMIT:59.
module tick_stopwatch_bcd #(
  parameter logic [7:0] MIN_LIMIT = 8'h59
) (
  input  logic clk,
  input  logic reset_n,
  tick_stopwatch_bcd_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t     r_state;
  state_t     w_nextState;
  logic       r_running;

  logic [3:0] r_secOnes, r_secTens, r_minOnes, r_minTens;
  logic [3:0] r_lapSecOnes, r_lapSecTens, r_lapMinOnes, r_lapMinTens;
  logic       r_lapValid;
  logic       r_wrap;
  logic       r_rollover;

  logic [3:0] w_nSecOnes, w_nSecTens, w_nMinOnes, w_nMinTens;
  logic       w_count;
  logic       w_secMax;
  logic       w_minMax;
  logic       w_wrap;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_running <= (w_nextState == RUN);
    end
  end

  // The command priority is clear, then stop, then start. A stop outside RUN has no effect.
  always_comb begin
    w_nextState = r_state;
    if (bus.clear) begin
      w_nextState = IDLE;
    end else if (bus.stop) begin
      if (r_state == RUN) begin
        w_nextState = PAUSE;
      end
    end else if (bus.start) begin
      w_nextState = RUN;
    end
  end

  assign w_count  = (r_state == RUN) && bus.tick;
  assign w_secMax = (r_secTens == 4'd5) && (r_secOnes == 4'd9);
  assign w_minMax = ({r_minTens, r_minOnes} == MIN_LIMIT);
  assign w_wrap   = w_count && w_secMax && w_minMax;

  always_comb begin
    w_nSecOnes = r_secOnes;
    w_nSecTens = r_secTens;
    w_nMinOnes = r_minOnes;
    w_nMinTens = r_minTens;
    if (w_count) begin
      if (r_secOnes != 4'd9) begin
        w_nSecOnes = r_secOnes + 4'd1;
      end else begin
        w_nSecOnes = 4'd0;
        if (r_secTens != 4'd5) begin
          w_nSecTens = r_secTens + 4'd1;
        end else begin
          w_nSecTens = 4'd0;
          if (w_minMax) begin
            w_nMinOnes = 4'd0;
            w_nMinTens = 4'd0;
          end else if (r_minOnes != 4'd9) begin
            w_nMinOnes = r_minOnes + 4'd1;
          end else begin
            w_nMinOnes = 4'd0;
            w_nMinTens = r_minTens + 4'd1;
          end
        end
      end
    end
  end

  // The lap registers capture the time from before this edge's increment. The rollover pulse
  // follows the wrap by one edge.
  always_ff @(posedge clk) begin
    if (!reset_n || bus.clear) begin
      r_secOnes    <= 4'd0;
      r_secTens    <= 4'd0;
      r_minOnes    <= 4'd0;
      r_minTens    <= 4'd0;
      r_lapSecOnes <= 4'd0;
      r_lapSecTens <= 4'd0;
      r_lapMinOnes <= 4'd0;
      r_lapMinTens <= 4'd0;
      r_lapValid   <= 1'b0;
      r_wrap       <= 1'b0;
      r_rollover   <= 1'b0;
    end else begin
      r_secOnes  <= w_nSecOnes;
      r_secTens  <= w_nSecTens;
      r_minOnes  <= w_nMinOnes;
      r_minTens  <= w_nMinTens;
      r_wrap     <= w_wrap;
      r_rollover <= r_wrap;
      if (bus.lap) begin
        r_lapSecOnes <= r_secOnes;
        r_lapSecTens <= r_secTens;
        r_lapMinOnes <= r_minOnes;
        r_lapMinTens <= r_minTens;
        r_lapValid   <= 1'b1;
      end
    end
  end

  assign bus.sec_ones     = r_secOnes;
  assign bus.sec_tens     = r_secTens;
  assign bus.min_ones     = r_minOnes;
  assign bus.min_tens     = r_minTens;
  assign bus.lap_sec_ones = r_lapSecOnes;
  assign bus.lap_sec_tens = r_lapSecTens;
  assign bus.lap_min_ones = r_lapMinOnes;
  assign bus.lap_min_tens = r_lapMinTens;
  assign bus.lap_valid    = r_lapValid;
  assign bus.running      = r_running;
  assign bus.rollover     = r_rollover;

endmodule

// File: tb/tb_tick_stopwatch_bcd.sv
// Bench for tick_stopwatch_bcd. Two instances (minute limits 59 and 09) share one stimulus stream.
// Both are compared every cycle against a seconds-count model, and some hand-computed values pin that model.
module tb_tick_stopwatch_bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n;
  logic tick, start, stop, clear, lap;

  tick_stopwatch_bcd_if busA ();
  tick_stopwatch_bcd_if busB ();

  assign busA.tick  = tick;
  assign busA.start = start;
  assign busA.stop  = stop;
  assign busA.clear = clear;
  assign busA.lap   = lap;
  assign busB.tick  = tick;
  assign busB.start = start;
  assign busB.stop  = stop;
  assign busB.clear = clear;
  assign busB.lap   = lap;

  tick_stopwatch_bcd #(.MIN_LIMIT(8'h59)) dutA (.clk(clk), .reset_n(reset_n), .bus(busA));
  tick_stopwatch_bcd #(.MIN_LIMIT(8'h09)) dutB (.clk(clk), .reset_n(reset_n), .bus(busB));

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  int nChecks = 0;
  int nPass   = 0;

  int limMin [2] = '{59, 9};
  int mSecs    [2];
  int mLapSecs [2];
  int mState   [2];
  bit mLapV    [2];
  bit mWrap    [2];
  bit mRoll    [2];
  bit modelLive = 1'b0;

  // The model keeps elapsed time as a plain count of seconds modulo the period. It is converted to digits only when compared.
  always @(posedge clk) begin
    bit counted;
    for (int k = 0; k < 2; k++) begin
      if (!reset_n || clear) begin
        mSecs[k]    = 0;
        mLapSecs[k] = 0;
        mLapV[k]    = 1'b0;
        mWrap[k]    = 1'b0;
        mRoll[k]    = 1'b0;
        mState[k]   = M_IDLE;
      end else begin
        counted  = (mState[k] == M_RUN) && tick;
        mRoll[k] = mWrap[k];
        mWrap[k] = counted && (mSecs[k] == (limMin[k] + 1) * 60 - 1);
        if (lap) begin
          mLapSecs[k] = mSecs[k];
          mLapV[k]    = 1'b1;
        end
        if (counted) mSecs[k] = (mSecs[k] + 1) % ((limMin[k] + 1) * 60);
        if (stop) begin
          if (mState[k] == M_RUN) mState[k] = M_PAUSE;
        end else if (start) begin
          mState[k] = M_RUN;
        end
      end
    end
    modelLive = 1'b1;
  end

  function automatic logic [15:0] toBcd(input int secs);
    int m;
    int s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic logic [34:0] modelPacked(input int k);
    return {toBcd(mSecs[k]), toBcd(mLapSecs[k]), mLapV[k], (mState[k] == M_RUN), mRoll[k]};
  endfunction

  function automatic logic [34:0] dutPacked(input int k);
    if (k == 0)
      return {busA.min_tens, busA.min_ones, busA.sec_tens, busA.sec_ones,
              busA.lap_min_tens, busA.lap_min_ones, busA.lap_sec_tens, busA.lap_sec_ones,
              busA.lap_valid, busA.running, busA.rollover};
    return {busB.min_tens, busB.min_ones, busB.sec_tens, busB.sec_ones,
            busB.lap_min_tens, busB.lap_min_ones, busB.lap_sec_tens, busB.lap_sec_ones,
            busB.lap_valid, busB.running, busB.rollover};
  endfunction

  task automatic checkOutput(input string name, input logic [34:0] actual, input logic [34:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: actual=%h expected=%h (time,lap,lapValid,running,rollover)",
                  name, actual, expected);
  endtask

  task automatic checkLiteral(input string name, input int k, input logic [15:0] t,
                              input logic [15:0] lt, input bit lv, input bit run, input bit roll);
    logic [34:0] exp;
    exp = {t, lt, lv, run, roll};
    checkOutput({name, ".model"}, modelPacked(k), exp);
    checkOutput({name, ".dut"}, dutPacked(k), exp);
  endtask

  always @(negedge clk) begin
    if (modelLive) begin
      checkOutput("cycle.limit59", dutPacked(0), modelPacked(0));
      checkOutput("cycle.limit09", dutPacked(1), modelPacked(1));
    end
  end

  task automatic applyStimulus(input bit t, input bit s, input bit p, input bit c, input bit l);
    tick  = t;
    start = s;
    stop  = p;
    clear = c;
    lap   = l;
    @(negedge clk);
  endtask

  task automatic tickN(input int n, input int gap);
    repeat (n) begin
      applyStimulus(1, 0, 0, 0, 0);
      repeat (gap) applyStimulus(0, 0, 0, 0, 0);
    end
  endtask

  initial begin
    int c;
    reset_n = 1'b0;
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkLiteral("reset", 0, 16'h0000, 16'h0000, 0, 0, 0);
    reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);
    checkLiteral("idleAfterReset", 0, 16'h0000, 16'h0000, 0, 0, 0);

    applyStimulus(0, 1, 0, 0, 0);
    checkLiteral("startRun", 0, 16'h0000, 16'h0000, 0, 1, 0);
    tickN(60, 2);
    checkLiteral("count60", 0, 16'h0100, 16'h0000, 0, 1, 0);
    tickN(15, 2);
    checkLiteral("count75", 0, 16'h0115, 16'h0000, 0, 1, 0);

    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    tickN(3598, 0);
    checkLiteral("pre5958", 0, 16'h5958, 16'h0000, 0, 1, 0);
    checkLiteral("pre0958", 1, 16'h0958, 16'h0000, 0, 1, 0);
    tickN(1, 0);
    checkLiteral("at5959", 0, 16'h5959, 16'h0000, 0, 1, 0);
    checkLiteral("at0959", 1, 16'h0959, 16'h0000, 0, 1, 0);
    tickN(1, 0);
    checkLiteral("wrap59", 0, 16'h0000, 16'h0000, 0, 1, 0);
    checkLiteral("wrap09", 1, 16'h0000, 16'h0000, 0, 1, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkLiteral("rollPulse59", 0, 16'h0000, 16'h0000, 0, 1, 1);
    checkLiteral("rollPulse09", 1, 16'h0000, 16'h0000, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkLiteral("rollEnd59", 0, 16'h0000, 16'h0000, 0, 1, 0);

    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    tickN(10, 0);
    applyStimulus(0, 0, 1, 0, 0);
    tickN(5, 1);
    checkLiteral("pauseHold", 0, 16'h0010, 16'h0000, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(1, 0, 1, 0, 0);
    checkLiteral("stopWithTick", 0, 16'h0011, 16'h0000, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkLiteral("startWithTick", 0, 16'h0011, 16'h0000, 0, 1, 0);
    tickN(1, 0);
    checkLiteral("afterResume", 0, 16'h0012, 16'h0000, 0, 1, 0);

    applyStimulus(0, 0, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    tickN(150, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkLiteral("lapAt0230", 0, 16'h0230, 16'h0230, 1, 1, 0);
    applyStimulus(1, 0, 1, 1, 1);
    checkLiteral("clearWins", 0, 16'h0000, 16'h0000, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkLiteral("clearNoRoll", 0, 16'h0000, 16'h0000, 0, 0, 0);

    applyStimulus(0, 1, 0, 0, 0);
    tickN(42, 0);
    applyStimulus(1, 0, 0, 0, 1);
    checkLiteral("lapWithTick", 0, 16'h0043, 16'h0042, 1, 1, 0);
    tickN(10, 0);
    checkLiteral("lapHeld", 0, 16'h0053, 16'h0042, 1, 1, 0);

    repeat (3000) begin
      reset_n = ($urandom_range(0, 199) != 0);
      c = $urandom_range(0, 199);
      applyStimulus(($urandom_range(0, 3) != 0), (c < 10), (c >= 10 && c < 20),
                    (c == 20), ($urandom_range(0, 19) == 0));
    end
    reset_n = 1'b1;
    applyStimulus(0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
